// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and constants for the AXI4-Lite to APB bridge
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int APB_PROT_W          = 3;
  localparam int APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - APB wait-state counter with terminal-count flag
module apb_wait_timer
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expired flags the last permitted wait cycle; a zero TIMEOUT never expires.
  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

  // Clear on the way into ACCESS, count stalled cycles, stop at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_stage.sv
// rtl/apb_master_stage.sv - APB4 master back end of the AXI4-Lite to APB bridge
module apb_master_stage
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [APB_PROT_W-1:0] pprot,
  input  logic                  pready,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;

  apb_state_e              state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [APB_PROT_W-1:0]   pprot_q, pprot_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    timer_clear, timer_enable, timer_expired;

  assign timer_clear  = (state_q == ST_SETUP);
  assign timer_enable = (state_q == ST_ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Handshake and bus-phase outputs decode straight from the state register.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and payload capture: request fields latch on accept, response on completion.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_SETUP;
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_write ? req_wdata : '0;
          pstrb_d  = req_write ? req_strb : '0;
          pprot_d  = req_prot;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d     = ST_RESP;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (timer_expired) begin
          state_d     = ST_RESP;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and payload registers; reset abandons any transfer in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_stage.sv
// tb/tb_apb_master_stage.sv - directed self-checking bench for apb_master_stage
module tb_apb_master_stage;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int tests;
  int fails;
  int access_cnt;
  logic done;

  apb_master_stage #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    aresetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_pprot", pprot, 0);
    aresetn = 1'b1;
    tick();

    // Write, zero wait states (pready already high through SETUP)
    drive_req(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b010);
    pready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_pwrite", pwrite, 1);
    check("wr_setup_paddr", paddr, 32'h1000);
    check("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    check("wr_setup_pstrb", pstrb, 4'hF);
    check("wr_setup_pprot", pprot, 3'b010);
    check("wr_setup_req_ready", req_ready, 0);
    check("wr_setup_rsp_valid", rsp_valid, 0);
    tick();
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    check("wr_access_rsp_valid", rsp_valid, 0);
    tick();
    pready = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_psel", psel, 0);
    check("wr_rsp_penable", penable, 0);
    check("wr_rsp_paddr_hold", paddr, 32'h1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", rsp_valid, 0);
    check("wr_done_req_ready", req_ready, 1);

    // Read with three wait states
    drive_req(1'b0, 32'h2004, 32'h12345678, 4'hF, 3'b000);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("rd_psel", psel, 1);
      check("rd_penable", penable, (k > 1) ? 1 : 0);
      check("rd_paddr", paddr, 32'h2004);
      check("rd_pwrite", pwrite, 0);
      check("rd_pstrb", pstrb, 0);
      check("rd_pwdata", pwdata, 0);
      check("rd_rsp_valid_early", rsp_valid, 0);
      if (k == 5) begin
        pready = 1'b1;
        prdata = 32'hCAFEF00D;
      end
      tick();
    end
    pready = 1'b0;
    prdata = 32'h0;
    check("rd_end_psel", psel, 0);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    check("rd_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read completing with pslverr
    drive_req(1'b0, 32'h3008, 32'h0, 4'h0, 3'b001);
    tick();
    req_valid = 1'b0;
    tick();
    check("err_access_penable", penable, 1);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA1234;
    tick();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 32'h55AA1234);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Timeout: pready never asserted
    drive_req(1'b0, 32'h4000, 32'h0, 4'h0, 3'b000);
    prdata = 32'hFFFFFFFF;
    tick();
    req_valid = 1'b0;
    access_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (psel && penable) access_cnt++;
      else done = 1'b1;
    end
    prdata = 32'h0;
    check("to_terminated", done, 1);
    check("to_access_cycles", access_cnt, 16);
    check("to_psel", psel, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Response backpressure with req_valid held high
    drive_req(1'b1, 32'h5000, 32'h11112222, 4'hF, 3'b000);
    pready = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 0);
      check("bp_rsp_err", rsp_err, 0);
      check("bp_req_ready", req_ready, 0);
      check("bp_psel", psel, 0);
      if (i == 4) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    check("bp_idle_psel", psel, 0);
    check("bp_idle_req_ready", req_ready, 1);
    check("bp_idle_rsp_valid", rsp_valid, 0);
    tick();
    req_valid = 1'b0;
    check("bp_next_setup_psel", psel, 1);
    check("bp_next_setup_penable", penable, 0);
    check("bp_next_setup_paddr", paddr, 32'h5000);
    tick(); tick();
    check("bp_next_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    pready = 1'b0;

    // Reset asserted during ACCESS
    drive_req(1'b0, 32'h6000, 32'h0, 4'h0, 3'b111);
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid_access_penable", penable, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rstmid_psel", psel, 0);
    check("rstmid_penable", penable, 0);
    check("rstmid_paddr", paddr, 0);
    check("rstmid_pprot", pprot, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_req_ready", req_ready, 1);
    tick();
    aresetn = 1'b1;
    tick();
    check("rstmid_no_rsp", rsp_valid, 0);
    check("rstmid_no_psel", psel, 0);

    // Normal transfer after reset
    drive_req(1'b1, 32'h7000, 32'h0BADF00D, 4'h3, 3'b001);
    pready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("post_setup_psel", psel, 1);
    check("post_setup_pstrb", pstrb, 4'h3);
    check("post_setup_pwdata", pwdata, 32'h0BADF00D);
    tick();
    check("post_access_penable", penable, 1);
    tick();
    pready = 1'b0;
    check("post_rsp_valid", rsp_valid, 1);
    check("post_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_idle_req_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_stage.md
# apb_master_stage

APB4 master back end of the AXI4-Lite to APB bridge. Accepts one decoded transfer request at a time from the AXI4-Lite front end over a valid/ready channel, runs the APB SETUP/ACCESS sequence on the peripheral bus, and returns read data and error status over a valid/ready response channel. A programmable wait-state timeout guarantees that a stalled peripheral cannot hang the bridge.

## Interface
Parameters:
- ADDR_W, 32, request address and paddr width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 16, maximum ACCESS cycles without pready before forced error; 0 disables the timeout

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - aclk  in  1  clock; all logic on rising edge
  - aresetn  in  1  asynchronous active-low reset
- Request channel (from the AXI4-Lite front end):
  - req_valid  in  1  request present
  - req_ready  out  1  request accepted when high with req_valid
  - req_write  in  1  1 = write, 0 = read
  - req_addr  in  ADDR_W  byte address
  - req_wdata  in  DATA_W  write data
  - req_strb  in  DATA_W/8  write byte strobes
  - req_prot  in  3  protection attributes
- Response channel (to the AXI4-Lite front end):
  - rsp_valid  out  1  response present
  - rsp_ready  in  1  response consumed
  - rsp_rdata  out  DATA_W  read data (0 for writes)
  - rsp_err  out  1  pslverr or timeout
- APB4 master:
  - psel, penable, pwrite  out  1 each
  - paddr  out  ADDR_W
  - pwdata  out  DATA_W
  - pstrb  out  DATA_W/8
  - pprot  out  3
  - pready  in  1
  - prdata  in  DATA_W
  - pslverr  in  1

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/addr/wdata/strb/prot and go to SETUP.
- SETUP:
  - psel=1, penable=0, APB outputs driven from the latched request.
  - Exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; outputs held stable.
  - Wait counter increments each cycle with pready=0.
  - pready=1: latch rsp_err=pslverr, and rsp_rdata=prdata for reads or 0 for writes; go to RESP.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with pready=0: rsp_err=1, rsp_rdata=0, go to RESP. psel and penable drop the next cycle; the transfer is abandoned.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready, go to IDLE.
  - req_ready=0 throughout.
- Reads drive pwrite=0, pstrb=0 and pwdata=0.
- Outside SETUP/ACCESS: psel=0, penable=0, paddr/pwdata/pstrb/pprot hold their last values.
- Unused state encodings go to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - psel=0, penable=0, pwrite=0.
  - paddr=0, pwdata=0, pstrb=0, pprot=0.
  - Wait counter 0.
- Latency, request handshake to rsp_valid: 2 + N cycles, where N = wait states (pready low cycles in ACCESS).
- Minimum period per transfer is 4 cycles: IDLE, SETUP, ACCESS, RESP.
- req_ready is registered (state-decoded). No combinational path from pready, rsp_ready or req_valid to any output.
- rsp_valid, once high, stays high with stable payload until rsp_ready.
- pready during SETUP is ignored.
- Reset asserted mid-ACCESS:
  - psel and penable drop immediately.
  - Any pending response is discarded.
  - No response is generated for the interrupted transfer.
- Wait counter width is clog2(TIMEOUT+1). It clears on entry to ACCESS.

## Structure
- Shared package apb_bridge_pkg holds:
  - The state enum (logic [1:0]: IDLE, SETUP, ACCESS, RESP).
  - APB_PROT_W=3.
  - Default TIMEOUT constant, shared with the AXI4-Lite front end.
- One natural sub-module, apb_wait_timer:
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT; expired is tied to 0 when TIMEOUT=0.

## Test plan
- Write 0x1000/0xDEADBEEF, strb 0xF, pready=1 at once -> SETUP then ACCESS each 1 cycle, pwrite=1, pstrb=0xF; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x2004, pready low 3 cycles, prdata=0xCAFEF00D -> psel high 5 cycles, paddr stable; rsp_rdata=0xCAFEF00D, rsp_err=0, pstrb=0.
- Read with pslverr=1 on the pready cycle -> rsp_err=1, rsp_rdata=prdata.
- TIMEOUT=16, pready never asserted -> exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- rsp_ready low 5 cycles, req_valid held high -> rsp payload stable, req_ready=0, no new SETUP until the cycle after the response handshake.
- aresetn low during ACCESS -> psel and penable 0 immediately, all outputs at reset values; the next request runs normally.
